// File: rtl/hough_pkg.sv
// hough_pkg: shared widths, sequencer state encoding and job config record (rev 1.0).
`default_nettype none
package hough_pkg;
   localparam int DIM_W  = 10;
   localparam int THR_W  = 8;
   localparam int ADDR_W = 17;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_KICK      = 3'd2,
      S_WAIT_LOW  = 3'd3,
      S_WAIT_HIGH = 3'd4,
      S_DONE      = 3'd5,
      S_ABORT     = 3'd6
   } state_t;

   typedef struct packed {
      logic [DIM_W-1:0] width;
      logic [DIM_W-1:0] height;
      logic [THR_W-1:0] threshold;
      logic [DIM_W-1:0] rho;
   } cfg_t;
endpackage
`default_nettype wire

// File: rtl/hough_bram_wr_stage.sv
// hough_bram_wr_stage: pixel address counter plus one-cycle registered BRAM write (rev 1.0).
`default_nettype none
module hough_bram_wr_stage
   import hough_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              beat,
   input  logic [DATA_W-1:0] pixel,
   output logic [ADDR_W-1:0] count,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
         we    <= 1'b0;
         addr  <= '0;
         data  <= '0;
      end else begin
         we <= beat;
         if (beat) begin
            addr <= count;
            data <= pixel;
         end
         // Counter only moves on accepted beats, so valid gaps never skip addresses.
         if (clr)
            count <= '0;
         else if (beat)
            count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/hough_load_seq.sv
// hough_load_seq: loads one image into the core BRAM, kicks the core and tracks completion (rev 1.0).
// Optional HOUGH_LOAD_CHECKSUM_EN adds csum_o, the mod-2^16 sum of accepted pixels.
`default_nettype none
module hough_load_seq
   import hough_pkg::*;
#(
   parameter int BRAM_DEPTH      = 131072,
   parameter int START_TIMEOUT   = 16,
   parameter int CORE_RST_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIM_W-1:0]  cfg_width_i,
   input  logic [DIM_W-1:0]  cfg_height_i,
   input  logic [THR_W-1:0]  cfg_threshold_i,
   input  logic [DIM_W-1:0]  cfg_rho_i,
   input  logic              cmd_start_i,
   input  logic              abort_i,
   output logic              cmd_busy_o,
   output logic              cmd_done_o,
   output logic              err_o,
   input  logic              pix_valid_i,
   input  logic [DATA_W-1:0] pix_data_i,
   output logic              pix_ready_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic [DATA_W-1:0] bram_data_o,
   output logic              bram_we_o,
   output logic [DIM_W-1:0]  core_width_o,
   output logic [DIM_W-1:0]  core_height_o,
   output logic [THR_W-1:0]  core_threshold_o,
   output logic [DIM_W-1:0]  core_rho_o,
   output logic              core_start_o,
   input  logic              core_ready_i,
   output logic              core_reset_o
`ifdef HOUGH_LOAD_CHECKSUM_EN
   ,
   output logic [15:0]       csum_o
`endif
);

   localparam int TOT_W = 2 * DIM_W;

   state_t            state, state_nx;
   cfg_t              cfg;
   logic [TOT_W-1:0]  total, total_in;
   logic [15:0]       tmr;
   logic [ADDR_W-1:0] count;
   logic              err, core_rst, beat, accept_start, cfg_bad, last_beat;

   assign total_in     = TOT_W'(cfg_width_i) * TOT_W'(cfg_height_i);
   assign cfg_bad      = (cfg_width_i == '0) || (cfg_height_i == '0) ||
                         (32'(total_in) > BRAM_DEPTH);
   assign accept_start = (state == S_IDLE) && cmd_start_i;
   assign beat         = pix_valid_i && (state == S_LOAD);
   assign last_beat    = beat && (TOT_W'(count) == total - 1'b1);

   always_ff @(posedge clk) begin
      if (!rst)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      if (cmd_start_i) state_nx = cfg_bad ? S_DONE : S_LOAD;
         S_LOAD:      if (last_beat) state_nx = S_KICK;
         S_KICK:      state_nx = S_WAIT_LOW;
         S_WAIT_LOW: begin
            if (!core_ready_i)
               state_nx = S_WAIT_HIGH;
            else if (tmr == 16'(START_TIMEOUT - 1))
               state_nx = S_DONE;
         end
         S_WAIT_HIGH: if (core_ready_i) state_nx = S_DONE;
         S_DONE:      state_nx = S_IDLE;
         S_ABORT:     if (tmr == 16'(CORE_RST_CYCLES - 1)) state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
      if (abort_i && (state != S_IDLE))
         state_nx = S_ABORT;
   end

   // tmr restarts on every state change; it times both the start timeout and the abort reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cfg      <= '0;
         total    <= '0;
         err      <= 1'b0;
         tmr      <= '0;
         core_rst <= 1'b1;
      end else begin
         core_rst <= (state_nx == S_ABORT);
         tmr      <= (state_nx != state) ? '0 : tmr + 1'b1;
         if (accept_start) begin
            cfg   <= '{width: cfg_width_i, height: cfg_height_i,
                       threshold: cfg_threshold_i, rho: cfg_rho_i};
            total <= total_in;
            err   <= cfg_bad;
         end else if ((state == S_WAIT_LOW) && (state_nx == S_DONE)) begin
            err <= 1'b1;
         end
      end
   end

   hough_bram_wr_stage u_wr (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept_start),
      .beat  (beat),
      .pixel (pix_data_i),
      .count (count),
      .we    (bram_we_o),
      .addr  (bram_addr_o),
      .data  (bram_data_o)
   );

`ifdef HOUGH_LOAD_CHECKSUM_EN
   logic [15:0] csum;
   always_ff @(posedge clk) begin
      if (!rst)
         csum <= '0;
      else if (accept_start)
         csum <= '0;
      else if (beat)
         csum <= csum + 16'(pix_data_i);
   end
   assign csum_o = csum;
`endif

   assign cmd_busy_o       = (state != S_IDLE);
   assign cmd_done_o       = (state == S_DONE);
   assign pix_ready_o      = (state == S_LOAD);
   assign core_start_o     = (state == S_KICK);
   assign core_reset_o     = core_rst;
   assign err_o            = err;
   assign core_width_o     = cfg.width;
   assign core_height_o    = cfg.height;
   assign core_threshold_o = cfg.threshold;
   assign core_rho_o       = cfg.rho;

endmodule
`default_nettype wire

// File: tb/tb_hough_load_seq.sv
// tb_hough_load_seq: directed vector table plus hand-written job sequences for hough_load_seq.
`default_nettype none
module tb_hough_load_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [9:0]  cfg_width_i = '0, cfg_height_i = '0, cfg_rho_i = '0;
   logic [7:0]  cfg_threshold_i = '0;
   logic        cmd_start_i = 1'b0, abort_i = 1'b0;
   logic        cmd_busy_o, cmd_done_o, err_o;
   logic        pix_valid_i = 1'b0;
   logic [7:0]  pix_data_i = '0;
   logic        pix_ready_o;
   logic [16:0] bram_addr_o;
   logic [7:0]  bram_data_o;
   logic        bram_we_o;
   logic [9:0]  core_width_o, core_height_o, core_rho_o;
   logic [7:0]  core_threshold_o;
   logic        core_start_o;
   logic        core_ready_i = 1'b1;
   logic        core_reset_o;
`ifdef HOUGH_LOAD_CHECKSUM_EN
   logic [15:0] csum_o;
`endif

   hough_load_seq dut (
      .clk(clk), .rst(rst),
      .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
      .cfg_threshold_i(cfg_threshold_i), .cfg_rho_i(cfg_rho_i),
      .cmd_start_i(cmd_start_i), .abort_i(abort_i),
      .cmd_busy_o(cmd_busy_o), .cmd_done_o(cmd_done_o), .err_o(err_o),
      .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .pix_ready_o(pix_ready_o),
      .bram_addr_o(bram_addr_o), .bram_data_o(bram_data_o), .bram_we_o(bram_we_o),
      .core_width_o(core_width_o), .core_height_o(core_height_o),
      .core_threshold_o(core_threshold_o), .core_rho_o(core_rho_o),
      .core_start_o(core_start_o), .core_ready_i(core_ready_i),
      .core_reset_o(core_reset_o)
`ifdef HOUGH_LOAD_CHECKSUM_EN
      , .csum_o(csum_o)
`endif
   );

   always #5 clk = ~clk;

   // Passive monitor on the falling edge: BRAM writes, start/done pulses.
   logic [16:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int n_start = 0, n_done = 0;
   always @(negedge clk) begin
      if (bram_we_o) begin
         wr_addr.push_back(bram_addr_o);
         wr_data.push_back(bram_data_o);
      end
      if (core_start_o) n_start++;
      if (cmd_done_o)   n_done++;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [9:0] w, input logic [9:0] h);
      cfg_width_i = w; cfg_height_i = h; cfg_threshold_i = 8'd10; cfg_rho_i = 10'd5;
      cmd_start_i = 1'b1;
      tick();
      cmd_start_i = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] d);
      pix_valid_i = 1'b1; pix_data_i = d;
      tick();
      pix_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!cmd_done_o && n < 64) begin tick(); n++; end
      chk(name, {31'd0, cmd_done_o}, 32'd1);
   endtask

   task automatic chk_writes(input string name, input int base, input int n,
                             input int addr0, input logic [7:0] d[$]);
      chk({name, "_count"}, wr_addr.size() - base, n);
      for (int i = 0; i < n && base + i < wr_addr.size(); i++) begin
         chk({name, "_addr"}, {15'd0, wr_addr[base + i]}, addr0 + i);
         chk({name, "_data"}, {24'd0, wr_data[base + i]}, {24'd0, d[i]});
      end
   endtask

   typedef struct {
      logic [9:0] w;
      logic [9:0] h;
      bit         exp_err;
   } vec_t;
   vec_t vecs[8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bw, bs, bd, cyc;
      logic [7:0] exp_d[$];

      vecs[0] = '{10'd4,   10'd3,   1'b0};
      vecs[1] = '{10'd0,   10'd5,   1'b1};
      vecs[2] = '{10'd5,   10'd0,   1'b1};
      vecs[3] = '{10'd512, 10'd512, 1'b1};
      vecs[4] = '{10'd256, 10'd512, 1'b0};
      vecs[5] = '{10'd512, 10'd257, 1'b1};
      vecs[6] = '{10'd1023,10'd1023,1'b1};
      vecs[7] = '{10'd1,   10'd1,   1'b0};

      // Reset state
      tick(); tick();
      chk("rst_busy", {31'd0, cmd_busy_o}, 0);
      chk("rst_core_reset", {31'd0, core_reset_o}, 1);
      chk("rst_we", {31'd0, bram_we_o}, 0);
      chk("rst_err", {31'd0, err_o}, 0);
      chk("rst_ready", {31'd0, pix_ready_o}, 0);
      chk("rst_start", {31'd0, core_start_o}, 0);
      rst = 1'b1;
      tick();
      chk("post_rst_core_reset", {31'd0, core_reset_o}, 0);

      // abort is ignored in IDLE
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      chk("idle_abort_busy", {31'd0, cmd_busy_o}, 0);
      chk("idle_abort_core_reset", {31'd0, core_reset_o}, 0);

      // Config acceptance table: bad dims go straight to DONE, good ones enter LOAD
      bw = wr_addr.size(); bs = n_start;
      for (int i = 0; i < 8; i++) begin
         start_job(vecs[i].w, vecs[i].h);
         chk($sformatf("vec%0d_err", i), {31'd0, err_o}, {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d_done", i), {31'd0, cmd_done_o}, {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d_pixready", i), {31'd0, pix_ready_o}, {31'd0, !vecs[i].exp_err});
         if (vecs[i].exp_err) begin
            tick();
         end else begin
            abort_i = 1'b1; tick(); abort_i = 1'b0;
            repeat (4) tick();
         end
         chk($sformatf("vec%0d_idle", i), {31'd0, cmd_busy_o}, 0);
      end
      chk("vec_no_writes", wr_addr.size() - bw, 0);
      chk("vec_no_start", n_start - bs, 0);

      // Job 1: 4x3 image, continuous stream, normal core handshake
      bw = wr_addr.size(); bs = n_start; bd = n_done;
      start_job(10'd4, 10'd3);
      chk("t1_err_cleared", {31'd0, err_o}, 0);
      exp_d = {};
      for (int i = 0; i < 12; i++) begin
         exp_d.push_back(8'(i));
         send_beat(8'(i));
      end
      chk("t1_kick", {31'd0, core_start_o}, 1);
      chk("t1_core_w", {22'd0, core_width_o}, 4);
      chk("t1_core_h", {22'd0, core_height_o}, 3);
      chk("t1_core_thr", {24'd0, core_threshold_o}, 10);
      chk("t1_core_rho", {22'd0, core_rho_o}, 5);
      tick(); tick();
      core_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) begin
         // a start while busy must be ignored (W=0 would flag an error if taken)
         if (i == 5) begin cfg_width_i = '0; cmd_start_i = 1'b1; end
         tick();
         cmd_start_i = 1'b0;
      end
      chk("t1_busy_wait_high", {31'd0, cmd_busy_o}, 1);
      core_ready_i = 1'b1;
      wait_done("t1_done");
      chk("t1_err", {31'd0, err_o}, 0);
`ifdef HOUGH_LOAD_CHECKSUM_EN
      chk("t1_csum", {16'd0, csum_o}, 66);
`endif
      tick();
      chk("t1_done_one_cycle", {31'd0, cmd_done_o}, 0);
      chk("t1_idle", {31'd0, cmd_busy_o}, 0);
      chk_writes("t1_wr", bw, 12, 0, exp_d);
      chk("t1_one_start", n_start - bs, 1);
      chk("t1_one_done", n_done - bd, 1);

      // Job 4: 2x2 with valid every third cycle, core never drops ready -> timeout
      bw = wr_addr.size(); bd = n_done;
      start_job(10'd2, 10'd2);
      exp_d = {};
      for (int k = 0; k < 4; k++) begin
         tick(); tick();
         exp_d.push_back(8'(8'hA0 + k));
         send_beat(8'(8'hA0 + k));
      end
      chk("t4_kick", {31'd0, core_start_o}, 1);
      cyc = 0;
      while (!cmd_done_o && cyc < 40) begin tick(); cyc++; end
      chk("t4_timeout_cycles", cyc, 17);
      chk("t4_err", {31'd0, err_o}, 1);
`ifdef HOUGH_LOAD_CHECKSUM_EN
      chk("t4_csum", {16'd0, csum_o}, 16'h0286);
`endif
      tick();
      chk("t4_one_done", n_done - bd, 1);
      chk_writes("t4_wr", bw, 4, 0, exp_d);

      // Job 5: abort after 5 beats; the beat in the abort cycle is still written
      bw = wr_addr.size(); bd = n_done;
      start_job(10'd4, 10'd3);
      exp_d = {};
      for (int i = 0; i < 5; i++) begin
         exp_d.push_back(8'(10 + i));
         send_beat(8'(10 + i));
      end
      exp_d.push_back(8'd99);
      abort_i = 1'b1; pix_valid_i = 1'b1; pix_data_i = 8'd99;
      tick();
      abort_i = 1'b0; pix_valid_i = 1'b0;
      chk("t5_pixready_abort", {31'd0, pix_ready_o}, 0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t5_core_reset%0d", i), {31'd0, core_reset_o}, 1);
         tick();
      end
      chk("t5_core_reset_end", {31'd0, core_reset_o}, 0);
      chk("t5_idle", {31'd0, cmd_busy_o}, 0);
      chk("t5_no_done", n_done - bd, 0);
      chk("t5_err_kept", {31'd0, err_o}, 0);
      chk_writes("t5_wr", bw, 6, 0, exp_d);

      bw = wr_addr.size();
      start_job(10'd1, 10'd2);
      exp_d = '{8'h55, 8'h66};
      send_beat(8'h55);
      send_beat(8'h66);
      tick();
      core_ready_i = 1'b0; tick(); core_ready_i = 1'b1;
      wait_done("t5b_done");
      tick();
      chk_writes("t5b_wr", bw, 2, 0, exp_d);

      // Job 6: reset in the middle of LOAD
      bw = wr_addr.size();
      start_job(10'd4, 10'd3);
      pix_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin pix_data_i = 8'(i); tick(); end
      rst = 1'b0;
      tick();
      chk("t6_busy", {31'd0, cmd_busy_o}, 0);
      chk("t6_we", {31'd0, bram_we_o}, 0);
      chk("t6_start", {31'd0, core_start_o}, 0);
      chk("t6_core_reset", {31'd0, core_reset_o}, 1);
      chk("t6_pixready", {31'd0, pix_ready_o}, 0);
      chk("t6_cfg_cleared", {22'd0, core_width_o}, 0);
      chk("t6_wr_before_rst", wr_addr.size() - bw, 8);
      rst = 1'b1; pix_valid_i = 1'b0;
      tick();
      chk("t6_core_reset_rel", {31'd0, core_reset_o}, 0);
      bw = wr_addr.size();
      start_job(10'd1, 10'd1);
      exp_d = '{8'h77};
      send_beat(8'h77);
      tick();
      core_ready_i = 1'b0; tick(); core_ready_i = 1'b1;
      wait_done("t6b_done");
      tick();
      chk_writes("t6b_wr", bw, 1, 0, exp_d);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
